weight_loop_ctrl: RTL

- Closes the CCSDS-123 weight feedback loop on the consumer side of the per-band weight store.
- For each accepted sample it selects the weight vector presented to the predictor:
  - row start (x==0): the recovered weight from the store (store read port output);
  - otherwise: the locally held weight from the previous update.
- Forwards every updated weight, one per sample, as the store's write stream (crt_data/w_en), so the store can capture the end-of-row weight per band.
- Sits between the weight store, the prediction datapath and the weight-update unit; it is the writer/consumer counterpart of the store.

---
 rtl/weight_loop_ctrl_pkg.sv | 17 +
 rtl/weight_loop_ctrl_bil_cnt.sv | 59 +++++
 rtl/weight_loop_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/weight_loop_ctrl_pkg.sv
// Shared definitions for the weight feedback loop and the per-band weight store.
// Keep these defaults in step with the store so both sides agree on widths.
package weight_loop_ctrl_pkg;

  localparam int unsigned WLC_X_LEN   = 11;
  localparam int unsigned WLC_Y_LEN   = 5;
  localparam int unsigned WLC_Z_LEN   = 8;
  localparam int unsigned WLC_W_WIDTH = 31;
  localparam int unsigned WLC_Z_INI   = 1;

  // Tag carried from sample accept to its matching weight update
  typedef struct packed {
    logic x_last;
    logic frame_last;
  } pend_tag_t;

endpackage

// File: rtl/weight_loop_ctrl_bil_cnt.sv
// BIL raster counter: x fastest, then z (Z_INI..Nz-1), then y.
// Wrap flags are combinational from the current position and the bounds.
module bil_cnt #(
  parameter int unsigned X_LEN = 11,
  parameter int unsigned Y_LEN = 5,
  parameter int unsigned Z_LEN = 8,
  parameter int unsigned Z_INI = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [X_LEN-1:0] i_nx,
  input  logic [Y_LEN-1:0] i_ny,
  input  logic [Z_LEN-1:0] i_nz,
  output logic [X_LEN-1:0] o_x,
  output logic [Y_LEN-1:0] o_y,
  output logic [Z_LEN-1:0] o_z,
  output logic             o_x_last,
  output logic             o_z_last,
  output logic             o_y_last
);

  logic [X_LEN-1:0] r_x;
  logic [Y_LEN-1:0] r_y;
  logic [Z_LEN-1:0] r_z;

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_z      = r_z;
  assign o_x_last = (r_x == i_nx - 1'b1);
  assign o_z_last = (r_z == i_nz - 1'b1);
  assign o_y_last = (r_y == i_ny - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_z <= Z_LEN'(Z_INI);
      r_y <= '0;
    end else if (i_load) begin
      r_x <= '0;
      r_z <= Z_LEN'(Z_INI);
      r_y <= '0;
    end else if (i_adv) begin
      if (!o_x_last) begin
        r_x <= r_x + 1'b1;
      end else begin
        r_x <= '0;
        if (!o_z_last) begin
          r_z <= r_z + 1'b1;
        end else begin
          r_z <= Z_LEN'(Z_INI);
          r_y <= o_y_last ? '0 : r_y + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/weight_loop_ctrl.sv
// Consumer side of the weight store: picks the predictor weight per sample
// (recovered at row start, locally held otherwise) and streams updates back.
module weight_loop_ctrl
  import weight_loop_ctrl_pkg::*;
#(
  parameter int unsigned X_LEN   = WLC_X_LEN,
  parameter int unsigned Y_LEN   = WLC_Y_LEN,
  parameter int unsigned Z_LEN   = WLC_Z_LEN,
  parameter int unsigned W_WIDTH = WLC_W_WIDTH,
  parameter int unsigned Z_INI   = WLC_Z_INI
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_ld_i,
  input  logic [X_LEN-1:0]   Nx,
  input  logic [Y_LEN-1:0]   Ny,
  input  logic [Z_LEN-1:0]   Nz,
  input  logic               s_en_i,
  output logic               s_rdy_o,
  input  logic [W_WIDTH-1:0] rec_data_i,
  input  logic               rec_en_i,
  output logic [W_WIDTH-1:0] cur_w_o,
  output logic               cur_en_o,
  input  logic [W_WIDTH-1:0] upd_data_i,
  input  logic               upd_en_i,
  output logic [W_WIDTH-1:0] wr_data_o,
  output logic               wr_en_o,
  output logic               row_last_o,
  output logic               frame_done_o,
  output logic               err_o
);

  logic [X_LEN-1:0]   r_nx;
  logic [Y_LEN-1:0]   r_ny;
  logic [Z_LEN-1:0]   r_nz;
  logic               r_pending;
  pend_tag_t          r_tag;
  logic [W_WIDTH-1:0] r_weight;
  logic [W_WIDTH-1:0] r_cur_w;
  logic               r_cur_en;
  logic [W_WIDTH-1:0] r_wr_data;
  logic               r_wr_en;
  logic               r_row_last;
  logic               r_frame_done;
  logic               r_err;

  logic [X_LEN-1:0]   w_x;
  logic [Y_LEN-1:0]   w_y;
  logic [Z_LEN-1:0]   w_z;
  logic               w_x_last;
  logic               w_z_last;
  logic               w_y_last;
  logic               w_cfg;
  logic               w_accept;
  logic               w_upd;

  bil_cnt #(
    .X_LEN (X_LEN),
    .Y_LEN (Y_LEN),
    .Z_LEN (Z_LEN),
    .Z_INI (Z_INI)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_cfg),
    .i_adv    (w_accept),
    .i_nx     (r_nx),
    .i_ny     (r_ny),
    .i_nz     (r_nz),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_z      (w_z),
    .o_x_last (w_x_last),
    .o_z_last (w_z_last),
    .o_y_last (w_y_last)
  );

  // A row start cannot be accepted until the store has the recovered weight
  assign s_rdy_o  = !r_pending && ((w_x != '0) || rec_en_i);
  assign w_accept = s_en_i && s_rdy_o;
  assign w_upd    = upd_en_i && r_pending;
  assign w_cfg    = cfg_ld_i && !r_pending;

  assign cur_w_o      = r_cur_w;
  assign cur_en_o     = r_cur_en;
  assign wr_data_o    = r_wr_data;
  assign wr_en_o      = r_wr_en;
  assign row_last_o   = r_row_last;
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nx         <= '0;
      r_ny         <= '0;
      r_nz         <= '0;
      r_pending    <= 1'b0;
      r_tag        <= '0;
      r_weight     <= '0;
      r_cur_w      <= '0;
      r_cur_en     <= 1'b0;
      r_wr_data    <= '0;
      r_wr_en      <= 1'b0;
      r_row_last   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_cfg) begin
        r_nx <= Nx;
        r_ny <= Ny;
        r_nz <= Nz;
      end

      r_cur_en <= w_accept;
      if (w_accept) begin
        r_cur_w          <= (w_x == '0) ? rec_data_i : r_weight;
        r_tag.x_last     <= w_x_last;
        r_tag.frame_last <= w_x_last && w_z_last && w_y_last;
      end

      r_wr_en      <= w_upd;
      r_row_last   <= w_upd && r_tag.x_last;
      r_frame_done <= w_upd && r_tag.frame_last;
      if (w_upd) begin
        r_wr_data <= upd_data_i;
        r_weight  <= upd_data_i;
      end

      // accept and update are mutually exclusive: accept needs !pending
      if (w_accept) begin
        r_pending <= 1'b1;
      end else if (w_upd) begin
        r_pending <= 1'b0;
      end

      if ((upd_en_i && !r_pending) || (cfg_ld_i && r_pending)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
